// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM arbiter: address packing, burst payload and FSM states.
package sdram_arb_pkg;

  localparam int unsigned BURST_LEN = 4;

  typedef struct packed {
    logic [2:0]  ba;
    logic [13:0] row;
    logic [8:0]  col;
  } sdram_addr_t;

  typedef logic [BURST_LEN-1:0][15:0] burst_t;

  typedef enum logic [2:0] {
    StIdle,
    StWrIssue,
    StWrWait,
    StRdIssue,
    StRdWait,
    StDone
  } arb_state_t;

endpackage

// File: rtl/sdram_arb_rr.sv
// Two-way round-robin picker; bit 0 is the write client, bit 1 the read client.
module sdram_arb_rr #(
  parameter bit WR_FIRST = 1'b1
) (
  input  logic       sclk,
  input  logic       srst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr_wr_q, ptr_wr_d;

  always_comb begin
    grant    = 2'b00;
    ptr_wr_d = ptr_wr_q;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_wr_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    // The pointer only moves when both clients actually contended for the slot.
    if (advance && (req == 2'b11)) begin
      ptr_wr_d = ~ptr_wr_q;
    end
  end

  always_ff @(posedge sclk) begin
    if (!srst_n) begin
      ptr_wr_q <= WR_FIRST;
    end else begin
      ptr_wr_q <= ptr_wr_d;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller between a write and a read client, one 4-word burst at a time,
// with round-robin fairness and a watchdog that aborts a burst the controller never completes.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1023,
  parameter bit          WR_FIRST    = 1'b1
) (
  input  logic             sclk,
  input  logic             srst_n,
  input  logic             wr_req,
  input  logic [25:0]      wr_addr,
  input  logic [3:0][15:0] wr_data,
  output logic             wr_ack,
  input  logic             rd_req,
  input  logic [25:0]      rd_addr,
  output logic             rd_ack,
  output logic [3:0][15:0] rd_data,
  output logic             err,
  output logic             busy,
  output logic [13:0]      ctl_row,
  output logic [8:0]       ctl_col,
  output logic [2:0]       ctl_ba,
  output logic [3:0][15:0] ctl_wdata,
  output logic             ctl_wtrig,
  input  logic             ctl_wfin,
  output logic             ctl_ren,
  input  logic             ctl_rclk,
  input  logic [3:0][15:0] ctl_rdata
);

  localparam int unsigned           WdogW    = $clog2(TIMEOUT_CYC + 1);
  // Last WAIT cycle before abort: WAIT lasts at most TIMEOUT_CYC cycles.
  localparam logic [WdogW-1:0]      WdogLast = WdogW'(TIMEOUT_CYC - 1);

  arb_state_t        state_q, state_d;
  sdram_addr_t       addr_q, addr_d;
  burst_t            wdata_q, wdata_d;
  burst_t            rdata_q, rdata_d;
  logic [WdogW-1:0]  wdog_q, wdog_d;
  logic              timeout_q, timeout_d;
  logic              is_wr_q, is_wr_d;
  logic              wfin_prev_q, rclk_prev_q;
  logic              wfin_rise, rclk_rise, wdog_hit;
  logic [1:0]        grant;

  sdram_arb_rr #(
    .WR_FIRST(WR_FIRST)
  ) u_rr (
    .sclk   (sclk),
    .srst_n (srst_n),
    .req    ({rd_req, wr_req}),
    .advance(state_q == StIdle),
    .grant  (grant)
  );

  assign wfin_rise = ctl_wfin & ~wfin_prev_q;
  assign rclk_rise = ctl_rclk & ~rclk_prev_q;
  assign wdog_hit  = (wdog_q == WdogLast);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
    is_wr_d   = is_wr_q;
    ctl_wtrig = 1'b0;
    ctl_ren   = 1'b0;
    wr_ack    = 1'b0;
    rd_ack    = 1'b0;
    err       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant[0]) begin
          state_d = StWrIssue;
          addr_d  = sdram_addr_t'(wr_addr);
          wdata_d = wr_data;
          is_wr_d = 1'b1;
        end else if (grant[1]) begin
          state_d = StRdIssue;
          addr_d  = sdram_addr_t'(rd_addr);
          is_wr_d = 1'b0;
        end
      end
      StWrIssue: begin
        ctl_wtrig = 1'b1;
        wdog_d    = '0;
        timeout_d = 1'b0;
        state_d   = StWrWait;
      end
      StRdIssue: begin
        ctl_ren   = 1'b1;
        wdog_d    = '0;
        timeout_d = 1'b0;
        state_d   = StRdWait;
      end
      StWrWait: begin
        wdog_d = wdog_q + WdogW'(1);
        if (wfin_rise) begin
          state_d = StDone;
        end else if (wdog_hit) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end
      end
      StRdWait: begin
        wdog_d = wdog_q + WdogW'(1);
        // Completion takes priority over a watchdog expiry in the same cycle.
        if (rclk_rise) begin
          state_d = StDone;
          rdata_d = ctl_rdata;
        end else if (wdog_hit) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end
      end
      StDone: begin
        wr_ack  = is_wr_q;
        rd_ack  = ~is_wr_q;
        err     = timeout_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (!srst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      wdog_q      <= '0;
      timeout_q   <= 1'b0;
      is_wr_q     <= 1'b0;
      wfin_prev_q <= 1'b0;
      rclk_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      wdog_q      <= wdog_d;
      timeout_q   <= timeout_d;
      is_wr_q     <= is_wr_d;
      wfin_prev_q <= ctl_wfin;
      rclk_prev_q <= ctl_rclk;
    end
  end

  assign busy      = (state_q != StIdle);
  assign ctl_row   = addr_q.row;
  assign ctl_col   = addr_q.col;
  assign ctl_ba    = addr_q.ba;
  assign ctl_wdata = wdata_q;
  assign rd_data   = rdata_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: a burst-level model checked every cycle, directed scenarios with
// hand-computed expectations, then randomized client and controller traffic.
module tb_sdram_arbiter;

  localparam int unsigned TO = 15;

  logic             sclk = 1'b0;
  logic             srst_n;
  logic             wr_req, rd_req;
  logic [25:0]      wr_addr, rd_addr;
  logic [3:0][15:0] wr_data, rd_data, ctl_wdata, ctl_rdata;
  logic             wr_ack, rd_ack, err, busy;
  logic [13:0]      ctl_row;
  logic [8:0]       ctl_col;
  logic [2:0]       ctl_ba;
  logic             ctl_wtrig, ctl_wfin, ctl_ren, ctl_rclk;

  always #5 sclk = ~sclk;

  sdram_arbiter #(
    .TIMEOUT_CYC(TO),
    .WR_FIRST   (1'b1)
  ) dut (
    .sclk     (sclk),
    .srst_n   (srst_n),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_ack   (rd_ack),
    .rd_data  (rd_data),
    .err      (err),
    .busy     (busy),
    .ctl_row  (ctl_row),
    .ctl_col  (ctl_col),
    .ctl_ba   (ctl_ba),
    .ctl_wdata(ctl_wdata),
    .ctl_wtrig(ctl_wtrig),
    .ctl_wfin (ctl_wfin),
    .ctl_ren  (ctl_ren),
    .ctl_rclk (ctl_rclk),
    .ctl_rdata(ctl_rdata)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Burst-level model: a burst decided in cycle s issues in s+1, waits from s+2, and
  // acknowledges in the cycle d that follows its completion or its TO-th wait cycle.
  bit          m_valid = 1'b0;
  bit          m_active, m_is_wr, m_err, m_ptr_wr, m_wfin_prev, m_rclk_prev;
  int          m_s, m_d;
  logic [25:0] m_addr;
  logic [63:0] m_wdata, m_rdata;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
    end
  endtask

  function automatic bit m_ack_now();
    return m_active && (m_d >= 0) && (cyc == m_d);
  endfunction

  task automatic compare();
    bit ack;
    ack = m_ack_now();
    chk("busy", 64'(busy), 64'(m_active && (cyc > m_s)));
    chk("ctl_wtrig", 64'(ctl_wtrig), 64'(m_active && m_is_wr && (cyc == m_s + 1)));
    chk("ctl_ren", 64'(ctl_ren), 64'(m_active && !m_is_wr && (cyc == m_s + 1)));
    chk("wr_ack", 64'(wr_ack), 64'(ack && m_is_wr));
    chk("rd_ack", 64'(rd_ack), 64'(ack && !m_is_wr));
    chk("err", 64'(err), 64'(ack && m_err));
    chk("ctl_addr", 64'({ctl_ba, ctl_row, ctl_col}), 64'(m_addr));
    chk("ctl_wdata", 64'(ctl_wdata), m_wdata);
    chk("rd_data", 64'(rd_data), m_rdata);
  endtask

  task automatic model_update();
    bit rise;
    if (!srst_n) begin
      m_valid     = 1'b1;
      m_active    = 1'b0;
      m_is_wr     = 1'b0;
      m_err       = 1'b0;
      m_ptr_wr    = 1'b1;
      m_wfin_prev = 1'b0;
      m_rclk_prev = 1'b0;
      m_addr      = '0;
      m_wdata     = '0;
      m_rdata     = '0;
      m_s         = 0;
      m_d         = -1;
      return;
    end
    if (m_active) begin
      if (m_ack_now()) begin
        m_active = 1'b0;
      end else if ((m_d < 0) && (cyc >= m_s + 2)) begin
        rise = m_is_wr ? (ctl_wfin && !m_wfin_prev) : (ctl_rclk && !m_rclk_prev);
        if (rise) begin
          m_d   = cyc + 1;
          m_err = 1'b0;
          if (!m_is_wr) m_rdata = ctl_rdata;
        end else if (cyc - (m_s + 2) == int'(TO) - 1) begin
          m_d   = cyc + 1;
          m_err = 1'b1;
        end
      end
    end else if (wr_req || rd_req) begin
      m_is_wr  = wr_req && (!rd_req || m_ptr_wr);
      if (wr_req && rd_req) m_ptr_wr = !m_ptr_wr;
      m_active = 1'b1;
      m_s      = cyc;
      m_d      = -1;
      if (m_is_wr) begin
        m_addr  = wr_addr;
        m_wdata = wr_data;
      end else begin
        m_addr = rd_addr;
      end
    end
    m_wfin_prev = ctl_wfin;
    m_rclk_prev = ctl_rclk;
  endtask

  // Inputs set before tick() are the ones the DUT samples at the coming edge.
  task automatic tick();
    model_update();
    @(posedge sclk);
    #1;
    cyc++;
    if (m_valid) compare();
  endtask

  // One uncontended burst; the matching flag is high for 3 cycles starting flag_at cycles
  // after the issue pulse (flag_at < 0: never). Latency is ack cycle minus issue cycle.
  task automatic burst(input bit is_wr, input logic [25:0] a, input logic [63:0] d,
                       input int flag_at, output int lat, output logic err_seen,
                       output int n_issue, output int n_ack);
    int t_iss, t_ack;
    bit flag;
    t_iss = -1; t_ack = -1; n_issue = 0; n_ack = 0; err_seen = 1'b0;
    if (is_wr) begin
      wr_addr = a; wr_data = d; wr_req = 1'b1;
    end else begin
      rd_addr = a; ctl_rdata = d; rd_req = 1'b1;
    end
    for (int i = 0; i < 80 && !((t_ack >= 0) && (cyc > t_ack + 3)); i++) begin
      tick();
      if (is_wr ? ctl_wtrig : ctl_ren) begin
        n_issue++;
        t_iss = cyc;
      end
      if (is_wr ? wr_ack : rd_ack) begin
        n_ack++;
        t_ack    = cyc;
        err_seen = err;
        if (is_wr) wr_req = 1'b0;
        else rd_req = 1'b0;
      end
      flag = (t_iss >= 0) && (flag_at >= 0) && (cyc >= t_iss + flag_at) &&
             (cyc < t_iss + flag_at + 3);
      if (is_wr) ctl_wfin = flag;
      else ctl_rclk = flag;
    end
    ctl_wfin = 1'b0;
    ctl_rclk = 1'b0;
    wr_req   = 1'b0;
    rd_req   = 1'b0;
    lat = ((t_ack >= 0) && (t_iss >= 0)) ? t_ack - t_iss : -1;
  endtask

  task automatic do_reset();
    srst_n = 1'b0;
    tick();
    srst_n = 1'b1;
  endtask

  initial begin : main
    int       lat, n_iss, n_ack, n_ovl, t_iss;
    logic     e;
    bit       iss_wr, flag, quiet;
    bit       order[6];
    bit       exp_order[6];
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    srst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; ctl_rdata = '0;
    ctl_wfin = 1'b0; ctl_rclk = 1'b0;
    tick();
    tick();
    srst_n = 1'b1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_acks", 64'({wr_ack, rd_ack, err, ctl_wtrig, ctl_ren}), 64'd0);
    chk("reset_rd_data", 64'(rd_data), 64'd0);
    chk("reset_ctl_addr", 64'({ctl_ba, ctl_row, ctl_col}), 64'd0);

    // Single write, wfin first high in the 10th cycle after the trigger.
    burst(1'b1, 26'h000_0004, {16'd7, 16'd6, 16'd5, 16'd4}, 10, lat, e, n_iss, n_ack);
    chk("wr_trig_pulses", 64'(n_iss), 64'd1);
    chk("wr_ack_count", 64'(n_ack), 64'd1);
    chk("wr_ack_latency", 64'(lat), 64'd11);
    chk("wr_err", 64'(e), 64'd0);
    chk("wr_ctl_col", 64'(ctl_col), 64'd4);
    chk("wr_ctl_wdata", 64'(ctl_wdata), 64'h0007_0006_0005_0004);

    // Single read of address 0 returning {0,1,2,3}.
    burst(1'b0, 26'h0, {16'd3, 16'd2, 16'd1, 16'd0}, 3, lat, e, n_iss, n_ack);
    chk("rd_ren_pulses", 64'(n_iss), 64'd1);
    chk("rd_ack_count", 64'(n_ack), 64'd1);
    chk("rd_ack_latency", 64'(lat), 64'd4);
    chk("rd_data_value", 64'(rd_data), 64'h0003_0002_0001_0000);

    // Read that the controller never completes: abort after TO wait cycles, data kept.
    burst(1'b0, 26'h155_5555, 64'hdead_beef_cafe_f00d, -1, lat, e, n_iss, n_ack);
    chk("to_ack_latency", 64'(lat), 64'(TO + 1));
    chk("to_err", 64'(e), 64'd1);
    chk("to_rd_data_kept", 64'(rd_data), 64'h0003_0002_0001_0000);

    // Next request after the abort, flag immediately in the first wait cycle.
    burst(1'b1, 26'h2aa_aaaa, 64'h1111_2222_3333_4444, 1, lat, e, n_iss, n_ack);
    chk("post_to_latency", 64'(lat), 64'd2);
    chk("post_to_err", 64'(e), 64'd0);

    // Completion rises in the very wait cycle where the watchdog expires.
    burst(1'b1, 26'h000_1234, 64'h5555_6666_7777_8888, int'(TO), lat, e, n_iss, n_ack);
    chk("tie_latency", 64'(lat), 64'(TO + 1));
    chk("tie_err", 64'(e), 64'd0);

    // Reset during WR_WAIT abandons the burst; a later wfin rise must not ack.
    wr_addr = 26'h3ff_ffff; wr_data = 64'habcd_ef01_2345_6789; wr_req = 1'b1;
    t_iss = -1;
    for (int i = 0; i < 10 && t_iss < 0; i++) begin
      tick();
      if (ctl_wtrig) t_iss = cyc;
    end
    chk("mid_rst_issued", 64'(t_iss >= 0), 64'd1);
    tick();
    tick();
    srst_n = 1'b0;
    wr_req = 1'b0;
    tick();
    srst_n = 1'b1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_addr", 64'({ctl_ba, ctl_row, ctl_col}), 64'd0);
    chk("mid_rst_wdata", 64'(ctl_wdata), 64'd0);
    ctl_wfin = 1'b1;
    n_ack = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (wr_ack || rd_ack) n_ack++;
    end
    chk("stale_wfin_ack", 64'(n_ack), 64'd0);
    ctl_wfin = 1'b0;
    tick();

    // Both clients saturated from reset: bursts must alternate starting with WR.
    do_reset();
    wr_addr = 26'($urandom); rd_addr = 26'($urandom);
    wr_data = {$urandom(), $urandom()};
    wr_req = 1'b1; rd_req = 1'b1;
    t_iss = -1; iss_wr = 1'b0; n_iss = 0; n_ack = 0; n_ovl = 0;
    for (int i = 0; i < 300 && n_ack < 6; i++) begin
      tick();
      if (ctl_wtrig && ctl_ren) n_ovl++;
      if (ctl_wtrig || ctl_ren) begin
        if (n_iss < 6) order[n_iss] = ctl_wtrig;
        n_iss++;
        t_iss  = cyc;
        iss_wr = ctl_wtrig;
      end
      if (wr_ack || rd_ack) begin
        n_ack++;
        if (n_ack == 6) begin
          wr_req = 1'b0;
          rd_req = 1'b0;
        end
      end
      flag     = (t_iss >= 0) && (cyc >= t_iss + 2) && (cyc < t_iss + 4);
      ctl_wfin = flag && iss_wr;
      ctl_rclk = flag && !iss_wr;
    end
    ctl_wfin = 1'b0; ctl_rclk = 1'b0;
    chk("rr_bursts", 64'(n_ack), 64'd6);
    chk("rr_overlap", 64'(n_ovl), 64'd0);
    for (int k = 0; k < 6; k++) chk($sformatf("rr_order_%0d", k), 64'(order[k]),
                                    64'(exp_order[k]));
    tick();
    tick();

    // Randomized clients and controller; quiet stretches force watchdog aborts.
    for (int i = 0; i < 4000; i++) begin
      quiet = ((i / 250) % 3) == 2;
      if (wr_req && m_ack_now() && m_is_wr) begin
        if ($urandom_range(0, 1) == 0) wr_req = 1'b0;
        wr_addr = 26'($urandom); wr_data = {$urandom(), $urandom()};
      end else if (!wr_req && ($urandom_range(0, 3) == 0)) begin
        wr_req = 1'b1; wr_addr = 26'($urandom); wr_data = {$urandom(), $urandom()};
      end
      if (rd_req && m_ack_now() && !m_is_wr) begin
        if ($urandom_range(0, 1) == 0) rd_req = 1'b0;
        rd_addr = 26'($urandom);
      end else if (!rd_req && ($urandom_range(0, 3) == 0)) begin
        rd_req = 1'b1; rd_addr = 26'($urandom);
      end
      ctl_wfin  = !quiet && ($urandom_range(0, 3) == 0);
      ctl_rclk  = !quiet && ($urandom_range(0, 3) == 0);
      ctl_rdata = {$urandom(), $urandom()};
      srst_n    = ($urandom_range(0, 599) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
